// File: rtl/safe_password_engine.sv
// Keypad password engine: collects BCD digits, checks them against a stored
// password on star, supports password change and lockout after repeated misses.
module safe_password_engine #(
  parameter int unsigned MAX_LEN     = 6,
  parameter int unsigned MIN_LEN     = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               power_on,
  input  logic               key_valid,
  input  logic [3:0]         key_data,
  input  logic               key_star,
  input  logic               change_req,
  output logic               match,
  output logic               mismatch,
  output logic               unlocked,
  output logic               changing,
  output logic               pw_set,
  output logic               pw_reject,
  output logic               locked,
  output logic [MAX_LEN-1:0] led_mask
);

  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_OFF, S_ENTRY, S_CHANGE, S_LOCKED} state_t;

  state_t                  state, state_n;
  logic [MAX_LEN-1:0][3:0] entry_buf, entry_buf_n;
  logic [MAX_LEN-1:0][3:0] pw, pw_n;
  logic [LEN_W-1:0]        len, len_n;
  logic [LEN_W-1:0]        slen, slen_n;
  logic                    ovf, ovf_n;
  logic [FAIL_W-1:0]       fail, fail_n;
  logic [LOCK_W-1:0]       lock_cnt, lock_cnt_n;
  logic                    unlocked_n, match_n, mismatch_n, pw_set_n, pw_reject_n;
  logic [MAX_LEN-1:0]      led_mask_n;
  logic                    hit;
  logic                    digit_ok;

  assign digit_ok = key_valid && (key_data <= 4'd9);

  // Entry equals stored password over the stored length, with no overflow
  always_comb begin
    hit = (len == slen) && !ovf;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < len) && (entry_buf[i] != pw[i])) hit = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    entry_buf_n = entry_buf;
    len_n       = len;
    ovf_n       = ovf;
    pw_n        = pw;
    slen_n      = slen;
    fail_n      = fail;
    lock_cnt_n  = lock_cnt;
    unlocked_n  = unlocked;
    match_n     = 1'b0;
    mismatch_n  = 1'b0;
    pw_set_n    = 1'b0;
    pw_reject_n = 1'b0;

    case (state)
      S_OFF: begin
        entry_buf_n = '0;
        len_n       = '0;
        ovf_n       = 1'b0;
        unlocked_n  = 1'b0;
        if (power_on) state_n = S_ENTRY;
      end

      S_ENTRY, S_CHANGE: begin
        if (!power_on) begin
          state_n     = S_OFF;
          entry_buf_n = '0;
          len_n       = '0;
          ovf_n       = 1'b0;
          unlocked_n  = 1'b0;
        end else if (key_star) begin
          entry_buf_n = '0;
          len_n       = '0;
          ovf_n       = 1'b0;
          if (state == S_ENTRY) begin
            if (hit) begin
              match_n    = 1'b1;
              unlocked_n = 1'b1;
              fail_n     = '0;
            end else begin
              mismatch_n = 1'b1;
              unlocked_n = 1'b0;
              if (fail >= FAIL_W'(MAX_TRIES - 1)) begin
                state_n    = S_LOCKED;
                lock_cnt_n = LOCK_W'(LOCK_CYCLES);
                fail_n     = '0;
              end else begin
                fail_n = fail + 1'b1;
              end
            end
          end else if ((len >= LEN_W'(MIN_LEN)) && !ovf) begin
            pw_n     = entry_buf;
            slen_n   = len;
            pw_set_n = 1'b1;
            state_n  = S_ENTRY;
          end else begin
            pw_reject_n = 1'b1;
          end
        end else if (change_req) begin
          // Only honoured from ENTRY after a successful match
          if ((state == S_ENTRY) && unlocked) begin
            state_n     = S_CHANGE;
            entry_buf_n = '0;
            len_n       = '0;
            ovf_n       = 1'b0;
            unlocked_n  = 1'b0;
          end
        end else if (digit_ok) begin
          if (len < LEN_W'(MAX_LEN)) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
              if (LEN_W'(i) == len) entry_buf_n[i] = key_data;
            end
            len_n = len + 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end

      S_LOCKED: begin
        // Lockout runs regardless of power_on; exits after LOCK_CYCLES cycles
        if (lock_cnt <= LOCK_W'(1)) begin
          lock_cnt_n = '0;
          state_n    = power_on ? S_ENTRY : S_OFF;
        end else begin
          lock_cnt_n = lock_cnt - 1'b1;
        end
      end

      default: state_n = S_OFF;
    endcase

    led_mask_n = '0;
    if ((state_n == S_ENTRY) || (state_n == S_CHANGE)) begin
      for (int i = 0; i < int'(MAX_LEN); i++) led_mask_n[i] = (len_n > LEN_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_OFF;
      entry_buf <= '0;
      len       <= '0;
      ovf       <= 1'b0;
      pw        <= '0;
      slen      <= LEN_W'(MAX_LEN);
      fail      <= '0;
      lock_cnt  <= '0;
      unlocked  <= 1'b0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
      pw_set    <= 1'b0;
      pw_reject <= 1'b0;
      changing  <= 1'b0;
      locked    <= 1'b0;
      led_mask  <= '0;
    end else begin
      state     <= state_n;
      entry_buf <= entry_buf_n;
      len       <= len_n;
      ovf       <= ovf_n;
      pw        <= pw_n;
      slen      <= slen_n;
      fail      <= fail_n;
      lock_cnt  <= lock_cnt_n;
      unlocked  <= unlocked_n;
      match     <= match_n;
      mismatch  <= mismatch_n;
      pw_set    <= pw_set_n;
      pw_reject <= pw_reject_n;
      changing  <= (state_n == S_CHANGE);
      locked    <= (state_n == S_LOCKED);
      led_mask  <= led_mask_n;
    end
  end

endmodule

// File: tb/tb_safe_password_engine.sv
// Directed bench for safe_password_engine with default parameters.
module tb_safe_password_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_star;
  logic       change_req;
  logic       match, mismatch, unlocked, changing, pw_set, pw_reject, locked;
  logic [5:0] led_mask;

  int total = 0;
  int bad   = 0;

  safe_password_engine #(
    .MAX_LEN(6), .MIN_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .power_on(power_on),
    .key_valid(key_valid), .key_data(key_data), .key_star(key_star),
    .change_req(change_req), .match(match), .mismatch(mismatch),
    .unlocked(unlocked), .changing(changing), .pw_set(pw_set),
    .pw_reject(pw_reject), .locked(locked), .led_mask(led_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick();
    key_valid = 1'b0;
    key_data  = 4'd0;
  endtask

  task automatic star();
    key_star = 1'b1;
    tick();
    key_star = 1'b0;
  endtask

  task automatic chg();
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
  endtask

  task automatic enter_zeros(input int n);
    for (int i = 0; i < n; i++) press(4'd0);
  endtask

  task automatic enter_4719();
    press(4'd4); press(4'd7); press(4'd1); press(4'd9);
  endtask

  task automatic do_reset();
    reset = 1'b1; power_on = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    key_star = 1'b0; change_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    power_on = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; power_on = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    key_star = 1'b0; change_req = 1'b0;
    tick(); tick();
    total++;
    if ({match, mismatch, unlocked, changing, pw_set, pw_reject, locked, led_mask} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {match, mismatch, unlocked, changing, pw_set, pw_reject, locked, led_mask});
    end
    reset = 1'b0;
    press(4'd3);
    total++;
    if (led_mask !== 6'd0) begin bad++; $display("FAIL off_keys_ignored led_mask=%b exp=000000", led_mask); end
    power_on = 1'b1;
    tick();
    total++;
    if ({unlocked, changing, locked, led_mask} !== 9'd0) begin
      bad++; $display("FAIL power_on_idle got=%b exp=0", {unlocked, changing, locked, led_mask});
    end
  endtask

  task automatic test_default_match();
    logic [5:0] exp_led;
    for (int i = 1; i <= 6; i++) begin
      press(4'd0);
      exp_led = 6'((1 << i) - 1);
      total++;
      if (led_mask !== exp_led) begin bad++; $display("FAIL led_step%0d led_mask=%b exp=%b", i, led_mask, exp_led); end
    end
    star();
    total++;
    if ({match, mismatch, unlocked, led_mask} !== 9'b101_000000) begin
      bad++; $display("FAIL default_match got=%b exp=101000000", {match, mismatch, unlocked, led_mask});
    end
    tick();
    total++;
    if ({match, unlocked} !== 2'b01) begin bad++; $display("FAIL match_one_cycle got=%b exp=01", {match, unlocked}); end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      press(4'd1); press(4'd2); press(4'd3);
      star();
      total++;
      if ({mismatch, match, locked} !== {2'b10, (t == 3)}) begin
        bad++; $display("FAIL lock_try%0d mis/match/locked=%b exp=%b", t, {mismatch, match, locked}, {2'b10, (t == 3)});
      end
    end
    n = 0;
    while (locked === 1'b1 && n < 2000) begin
      n++;
      key_valid  = 1'b1;
      key_data   = 4'(n % 10);
      key_star   = (n % 7 == 0);
      change_req = (n % 5 == 0);
      tick();
      key_valid = 1'b0; key_star = 1'b0; change_req = 1'b0;
    end
    total++;
    if (n !== 1024) begin bad++; $display("FAIL lock_duration cycles=%0d exp=1024", n); end
    total++;
    if ({led_mask, mismatch, match, changing} !== 9'd0) begin
      bad++; $display("FAIL lock_keys_ignored got=%b exp=0", {led_mask, mismatch, match, changing});
    end
    press(4'd0);
    total++;
    if (led_mask !== 6'b000001) begin bad++; $display("FAIL post_lock_entry led_mask=%b exp=000001", led_mask); end
    enter_zeros(5);
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL post_lock_match match=%b exp=1", match); end
  endtask

  task automatic test_change();
    chg();
    total++;
    if ({changing, unlocked} !== 2'b10) begin bad++; $display("FAIL enter_change got=%b exp=10", {changing, unlocked}); end
    enter_4719();
    star();
    total++;
    if ({pw_set, pw_reject, changing} !== 3'b100) begin
      bad++; $display("FAIL pw_set got=%b exp=100", {pw_set, pw_reject, changing});
    end
    enter_4719();
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL new_pw_match match=%b exp=1", match); end
    enter_zeros(6);
    star();
    total++;
    if ({match, mismatch} !== 2'b01) begin bad++; $display("FAIL old_pw_rejected got=%b exp=01", {match, mismatch}); end
    enter_4719();
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL rematch match=%b exp=1", match); end
  endtask

  task automatic test_change_reject();
    chg();
    press(4'd1); press(4'd2); press(4'd3);
    star();
    total++;
    if ({pw_reject, pw_set, changing} !== 3'b101) begin
      bad++; $display("FAIL short_reject got=%b exp=101", {pw_reject, pw_set, changing});
    end
    for (int i = 1; i <= 7; i++) press(4'(i));
    total++;
    if (led_mask !== 6'b111111) begin bad++; $display("FAIL change_ovf_led led_mask=%b exp=111111", led_mask); end
    star();
    total++;
    if ({pw_reject, pw_set, changing, led_mask} !== 9'b101_000000) begin
      bad++; $display("FAIL overflow_reject got=%b exp=101000000", {pw_reject, pw_set, changing, led_mask});
    end
    press(4'd5); press(4'd5); press(4'd5); press(4'd5);
    power_on = 1'b0;
    tick();
    total++;
    if ({changing, unlocked, led_mask} !== 8'd0) begin
      bad++; $display("FAIL power_drop got=%b exp=0", {changing, unlocked, led_mask});
    end
    power_on = 1'b1;
    tick();
    enter_4719();
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL pw_kept_after_drop match=%b exp=1", match); end
  endtask

  task automatic test_overflow();
    do_reset();
    enter_zeros(6);
    press(4'd0);
    total++;
    if (led_mask !== 6'b111111) begin bad++; $display("FAIL ovf_led led_mask=%b exp=111111", led_mask); end
    star();
    total++;
    if ({mismatch, match} !== 2'b10) begin bad++; $display("FAIL ovf_mismatch got=%b exp=10", {mismatch, match}); end
    enter_zeros(2);
    press(4'hA);
    total++;
    if (led_mask !== 6'b000011) begin bad++; $display("FAIL bad_code_ignored led_mask=%b exp=000011", led_mask); end
    enter_zeros(3);
    key_valid = 1'b1; key_data = 4'd0; key_star = 1'b1;
    tick();
    key_valid = 1'b0; key_star = 1'b0;
    total++;
    if ({mismatch, match, led_mask} !== 8'b10_000000) begin
      bad++; $display("FAIL star_beats_digit got=%b exp=10000000", {mismatch, match, led_mask});
    end
    enter_zeros(6);
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL ovf_recover match=%b exp=1", match); end
  endtask

  task automatic test_change_no_unlock();
    do_reset();
    chg();
    total++;
    if (changing !== 1'b0) begin bad++; $display("FAIL chg_without_match changing=%b exp=0", changing); end
    press(4'd9);
    key_valid = 1'b1; key_data = 4'd1; change_req = 1'b1;
    tick();
    key_valid = 1'b0; change_req = 1'b0;
    total++;
    if ({changing, led_mask} !== 7'b0_000001) begin
      bad++; $display("FAIL chg_beats_digit got=%b exp=0000001", {changing, led_mask});
    end
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    enter_zeros(6); star();
    chg(); enter_4719(); star();
    for (int t = 0; t < 3; t++) begin
      press(4'd1); press(4'd2); press(4'd3); star();
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_before_reset locked=%b exp=1", locked); end
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #2;
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL async_reset_lock locked=%b exp=0", locked); end
    tick();
    reset = 1'b0;
    tick();
    enter_zeros(6);
    star();
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL default_restored match=%b exp=1", match); end
  endtask

  initial begin
    test_reset();
    test_default_match();
    test_lockout();
    test_change();
    test_change_reject();
    test_overflow();
    test_change_no_unlock();
    test_reset_in_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/safe_password_engine.md
Name: safe_password_engine

Overview:
Parametrised, clocked password engine for the digital safe. It collects BCD keypad digits into an entry buffer and checks the entry against a stored password when star is pressed. It supports a password change with a minimum/maximum length check, counts failed attempts, and locks the keypad out after too many failures. It sits between the keypad debouncer/encoder and the lock actuator/LED drivers.

Parameters:
MAX_LEN, 6, maximum password/entry length in digits (>=1)
MIN_LEN, 4, minimum length accepted for a new password (1..MAX_LEN)
MAX_TRIES, 3, consecutive mismatches that trigger lockout (>=1)
LOCK_CYCLES, 1024, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, asynchronous, active-high
power_on  in  1  safe powered/awake; level
key_valid  in  1  one-cycle strobe: key_data holds a pressed digit
key_data  in  4  BCD digit; codes >9 are ignored
key_star  in  1  one-cycle strobe: star (submit) pressed
change_req  in  1  one-cycle strobe: request password change
match  out  1  one-cycle pulse: entry equals stored password
mismatch  out  1  one-cycle pulse: entry rejected
unlocked  out  1  level: last submission matched; change permitted
changing  out  1  level: in CHANGE state
pw_set  out  1  one-cycle pulse: new password stored
pw_reject  out  1  one-cycle pulse: new password refused (bad length/overflow)
locked  out  1  level: in LOCKED state
led_mask  out  MAX_LEN  thermometer of entry length (bit i = 1 iff len > i)

Behaviour:
- Internal widths: LEN_W=clog2(MAX_LEN+1), fail counter clog2(MAX_TRIES+1), lock counter clog2(LOCK_CYCLES+1).
- Storage: entry buffer MAX_LEN x 4 bits, entry length len, sticky overflow flag, stored password MAX_LEN x 4 bits, stored length slen.
- Reset:
  - Stored password = all 0, slen = MAX_LEN, so the default password is MAX_LEN zeros.
  - Entry buffer and len cleared, overflow = 0, fail count = 0, state OFF.
  - All outputs 0.
- States: OFF, ENTRY, CHANGE, LOCKED. All outputs are registered. Pulses appear the cycle after the triggering strobe is sampled.
- OFF:
  - Buffer, len, overflow and unlocked are cleared. Keys are ignored.
  - Moves to ENTRY on the first cycle power_on=1.
- power_on=0 in ENTRY or CHANGE: go to OFF next cycle. A change in progress is abandoned; the stored password is unchanged.
- Digit handling (ENTRY/CHANGE, key_valid=1, key_data<=9, key_star=0):
  - If len<MAX_LEN: buf[len]=key_data, len+1.
  - Else: digit dropped and overflow=1.
- Priority: key_star > change_req > key_valid in the same cycle. Lower-priority strobes in that cycle are discarded.
- ENTRY + key_star:
  - Hit requires len==slen, buf[i]==stored[i] for all i<len, and overflow=0.
  - Hit: match pulse, unlocked=1, fail=0.
  - Miss: mismatch pulse, unlocked=0, fail+1. If fail reaches MAX_TRIES: enter LOCKED, lock counter = LOCK_CYCLES, fail=0.
  - Buffer, len and overflow are cleared in either case.
  - Star with len=0 is evaluated normally (a miss unless slen=0, which cannot occur).
- ENTRY + change_req:
  - If unlocked=1: go to CHANGE, clear buffer, unlocked=0.
  - Otherwise ignored.
- CHANGE + key_star:
  - If MIN_LEN<=len<=MAX_LEN and overflow=0: copy buf to stored, slen=len, pw_set pulse, go to ENTRY.
  - Otherwise: pw_reject pulse, stay in CHANGE.
  - Buffer cleared in both cases. Mismatch/fail counting does not apply in CHANGE.
- CHANGE + change_req: ignored.
- LOCKED:
  - locked=1. All key strobes ignored. Lock counter decrements every cycle.
  - Lockout persists through power_on=0.
  - When the counter reaches 0: locked=0 next cycle; go to ENTRY if power_on=1, else OFF.
- led_mask follows len. It reads 0 in OFF and LOCKED.
- Reset mid-operation (any state): immediate return to reset values, including the stored password.

Test Plan:
- Reset, power_on=1, keys 0,0,0,0,0,0, star -> match=1 for 1 cycle, unlocked=1, led_mask stepped 000001..111111 then 000000.
- Default password; enter 1,2,3 + star three times -> mismatch pulses 3x; locked=1 after the third; digits ignored for 1024 cycles; then locked=0 and state ENTRY; 0x6 + star -> match.
- After match: change_req, keys 4,7,1,9, star -> pw_set=1; enter 4,7,1,9 + star -> match; enter 0x6 + star -> mismatch.
- In CHANGE: keys 1,2,3 + star -> pw_reject, stays changing=1. Then 7 digits + star -> pw_reject (overflow), old password still valid.
- Enter 0x7 zeros + star with default password -> mismatch (overflow), led_mask stays 111111 on the 7th digit. key_valid+key_star in the same cycle -> digit dropped.
- change_req without a prior match -> ignored. power_on drop during CHANGE -> OFF, old password still valid. Reset asserted during LOCKED -> locked=0 immediately, default password restored.
